// File: rtl/dm_load_unit.sv
// ============================================================================
//  Module   : dm_load_unit
//  Brief    : Load path to data memory. Issues a word-aligned read, waits for
//             the ack or a timeout, then extracts and extends the loaded value.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_load_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        LdReq,
   input  logic [2:0]  LdType,
   input  logic [31:0] Addr,
   input  logic        Flush,
   output logic        MemRd,
   output logic [31:0] MemAddr,
   input  logic [31:0] MemRData,
   input  logic        MemAck,
   output logic [31:0] RDOut,
   output logic        LdDone,
   output logic        Stall,
   output logic        AdEL,
   output logic        BusErr
);

   localparam int              c_cw       = $clog2(TIMEOUT + 1);
   localparam logic [c_cw-1:0] c_cnt_last = c_cw'(TIMEOUT - 1);

   localparam logic [2:0] c_lw  = 3'b001;
   localparam logic [2:0] c_lh  = 3'b010;
   localparam logic [2:0] c_lhu = 3'b011;
   localparam logic [2:0] c_lb  = 3'b100;
   localparam logic [2:0] c_lbu = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [c_cw-1:0] r_cnt;
   logic [2:0]      r_type;
   logic [1:0]      r_off;
   logic            r_mem_rd;
   logic [31:0]     r_mem_addr;
   logic [31:0]     r_rd_out;
   logic            r_ld_done;
   logic            r_bus_err;
   logic            r_adel;

   logic            w_legal;
   logic            w_aligned;
   logic            w_accept;
   logic            w_misalign;
   logic            w_timeout;

   function automatic logic [31:0] extract(input logic [2:0]  t,
                                           input logic [1:0]  o,
                                           input logic [31:0] d);
      logic [15:0] h;
      logic [7:0]  b;
      logic [31:0] res;
      h = o[1] ? d[31:16] : d[15:0];
      case (o)
         2'b00:   b = d[7:0];
         2'b01:   b = d[15:8];
         2'b10:   b = d[23:16];
         default: b = d[31:24];
      endcase
      case (t)
         c_lw:    res = d;
         c_lh:    res = {{16{h[15]}}, h};
         c_lhu:   res = {16'h0000, h};
         c_lb:    res = {{24{b[7]}}, b};
         c_lbu:   res = {24'h000000, b};
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   always_comb begin
      w_legal = (LdType >= c_lw) && (LdType <= c_lbu);
      case (LdType)
         c_lw:        w_aligned = (Addr[1:0] == 2'b00);
         c_lh, c_lhu: w_aligned = ~Addr[0];
         default:     w_aligned = 1'b1;
      endcase
      w_accept   = (r_state == S_IDLE) && LdReq && w_legal &&  w_aligned && !Flush;
      w_misalign = (r_state == S_IDLE) && LdReq && w_legal && !w_aligned && !Flush;
      w_timeout  = (r_state == S_WAIT) && (r_cnt == c_cnt_last) && !MemAck;
   end

   always_comb begin
      w_next = r_state;
      Stall  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = S_WAIT;
               Stall  = 1'b1;
            end
         end
         S_WAIT: begin
            Stall = 1'b1;
            if (Flush)
               w_next = S_IDLE;
            else if (MemAck || w_timeout)
               w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_type     <= 3'b000;
         r_off      <= 2'b00;
         r_mem_rd   <= 1'b0;
         r_mem_addr <= 32'h0000_0000;
         r_rd_out   <= 32'h0000_0000;
         r_ld_done  <= 1'b0;
         r_bus_err  <= 1'b0;
         r_adel     <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_ld_done <= 1'b0;
         r_bus_err <= 1'b0;
         r_adel    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_accept) begin
                  r_type     <= LdType;
                  r_off      <= Addr[1:0];
                  r_mem_addr <= {Addr[31:2], 2'b00};
                  r_mem_rd   <= 1'b1;
               end else if (w_misalign) begin
                  r_adel <= 1'b1;
               end
            end
            S_WAIT: begin
               // Flush discards any ack arriving in the same cycle.
               if (Flush) begin
                  r_mem_rd <= 1'b0;
                  r_cnt    <= '0;
               end else if (MemAck) begin
                  r_rd_out  <= extract(r_type, r_off, MemRData);
                  r_mem_rd  <= 1'b0;
                  r_ld_done <= 1'b1;
               end else if (w_timeout) begin
                  r_rd_out  <= 32'h0000_0000;
                  r_mem_rd  <= 1'b0;
                  r_bus_err <= 1'b1;
                  r_ld_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_cnt <= '0;
            end
            default: begin
               r_cnt    <= '0;
               r_mem_rd <= 1'b0;
            end
         endcase
      end
   end

   // A flush arriving during DONE still cancels the completion pulses.
   assign LdDone  = r_ld_done & ~Flush;
   assign BusErr  = r_bus_err & ~Flush;
   assign MemRd   = r_mem_rd;
   assign MemAddr = r_mem_addr;
   assign RDOut   = r_rd_out;
   assign AdEL    = r_adel;

endmodule

`default_nettype wire

// File: tb/tb_dm_load_unit.sv
// ============================================================================
//  Module   : tb_dm_load_unit
//  Brief    : Directed vector bench for dm_load_unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_load_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        LdReq;
   logic [2:0]  LdType;
   logic [31:0] Addr;
   logic        Flush;
   logic        MemRd;
   logic [31:0] MemAddr;
   logic [31:0] MemRData;
   logic        MemAck;
   logic [31:0] RDOut;
   logic        LdDone;
   logic        Stall;
   logic        AdEL;
   logic        BusErr;

   int checks = 0;
   int fails  = 0;

   dm_load_unit #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .LdReq(LdReq), .LdType(LdType), .Addr(Addr),
      .Flush(Flush), .MemRd(MemRd), .MemAddr(MemAddr), .MemRData(MemRData),
      .MemAck(MemAck), .RDOut(RDOut), .LdDone(LdDone), .Stall(Stall),
      .AdEL(AdEL), .BusErr(BusErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  t;
      logic [31:0] a;
      logic [31:0] d;
      int          dly;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                          input int dly, input logic [31:0] exp, input string nm);
      LdType = t; Addr = a; LdReq = 1'b1;
      #1 chk({nm, " stall_req"}, Stall, 1);
      tick();
      LdReq = 1'b0; LdType = 3'b000;
      #1 chk({nm, " memrd"}, MemRd, 1);
      chk({nm, " memaddr"}, MemAddr, {a[31:2], 2'b00});
      for (int i = 0; i < dly; i++) tick();
      MemRData = d; MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      #1 chk({nm, " lddone"}, LdDone, 1);
      chk({nm, " rdout"}, RDOut, exp);
      chk({nm, " stall_done"}, Stall, 0);
      chk({nm, " memrd_done"}, MemRd, 0);
      chk({nm, " buserr"}, BusErr, 0);
      tick();
      #1 chk({nm, " lddone_pulse"}, LdDone, 0);
   endtask

   initial begin
      int cnt;
      vt[0] = '{3'b100, 32'h0000_1003, 32'h80FF_1234, 2,  32'hFFFF_FF80};
      vt[1] = '{3'b011, 32'h0000_1002, 32'h8001_7FFF, 0,  32'h0000_8001};
      vt[2] = '{3'b010, 32'h0000_1000, 32'h8001_7FFF, 1,  32'h0000_7FFF};
      vt[3] = '{3'b101, 32'h0000_1001, 32'h8001_7FFF, 0,  32'h0000_007F};
      vt[4] = '{3'b001, 32'h0000_1004, 32'hDEAD_BEEF, 3,  32'hDEAD_BEEF};
      vt[5] = '{3'b010, 32'h0000_2002, 32'h8001_0000, 0,  32'hFFFF_8001};
      vt[6] = '{3'b100, 32'h0000_2000, 32'h0000_00FF, 0,  32'hFFFF_FFFF};
      vt[7] = '{3'b101, 32'h0000_2002, 32'h00AB_0000, 1,  32'h0000_00AB};
      vt[8] = '{3'b001, 32'h0000_2008, 32'h1357_9BDF, 15, 32'h1357_9BDF};

      reset = 1'b1; LdReq = 1'b0; LdType = 3'b000; Addr = 32'h0;
      Flush = 1'b0; MemRData = 32'h0; MemAck = 1'b0;
      tick(); tick();
      chk("reset memrd", MemRd, 0);
      chk("reset memaddr", MemAddr, 0);
      chk("reset rdout", RDOut, 0);
      chk("reset flags", {28'h0, LdDone, AdEL, BusErr, Stall}, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 9; i++)
         do_load(vt[i].t, vt[i].a, vt[i].d, vt[i].dly, vt[i].exp, $sformatf("vec%0d", i));

      // Misaligned lw and lhu: AdEL pulse, no bus access
      LdType = 3'b001; Addr = 32'h0000_1002; LdReq = 1'b1;
      #1 chk("adel stall", Stall, 0);
      tick();
      LdReq = 1'b0;
      #1 chk("adel pulse", AdEL, 1);
      chk("adel memrd", MemRd, 0);
      tick();
      #1 chk("adel end", {29'h0, AdEL, MemRd, LdDone}, 0);
      LdType = 3'b011; Addr = 32'h0000_1003; LdReq = 1'b1;
      tick();
      LdReq = 1'b0;
      #1 chk("adel lhu", {30'h0, AdEL, MemRd}, 32'h2);
      tick();

      // Timeout: MemRd high exactly 16 cycles
      LdType = 3'b001; Addr = 32'h0000_2000; LdReq = 1'b1;
      tick();
      LdReq = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (!MemRd) break;
         cnt++;
         tick();
      end
      #1 chk("to memrd_cycles", cnt, 16);
      chk("to buserr", BusErr, 1);
      chk("to lddone", LdDone, 1);
      chk("to rdout", RDOut, 0);
      tick();
      #1 chk("to pulse_end", {30'h0, BusErr, LdDone}, 0);

      // Successful load restores a known RDOut before the flush test
      do_load(3'b001, 32'h0000_3000, 32'hA5A5_0F0F, 0, 32'hA5A5_0F0F, "preflush");

      // Flush in WAIT, late ack ignored
      LdType = 3'b001; Addr = 32'h0000_3004; LdReq = 1'b1;
      tick();
      LdReq = 1'b0;
      tick(); tick();
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      #1 chk("flush memrd", MemRd, 0);
      chk("flush stall", Stall, 0);
      chk("flush lddone", LdDone, 0);
      tick();
      MemRData = 32'h1234_5678; MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      #1 chk("flush late_ack", {30'h0, LdDone, MemRd}, 0);
      chk("flush rdout_hold", RDOut, 32'hA5A5_0F0F);
      tick();

      // Flush during DONE suppresses LdDone
      LdType = 3'b001; Addr = 32'h0000_3008; LdReq = 1'b1;
      tick();
      LdReq = 1'b0;
      MemRData = 32'h0BAD_F00D; MemAck = 1'b1;
      tick();
      MemAck = 1'b0; Flush = 1'b1;
      #1 chk("flushdone lddone", LdDone, 0);
      tick();
      Flush = 1'b0;
      tick();

      // Reset in WAIT
      LdType = 3'b001; Addr = 32'h0000_4000; LdReq = 1'b1;
      tick();
      LdReq = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      #1 chk("midrst memrd", MemRd, 0);
      chk("midrst memaddr", MemAddr, 0);
      chk("midrst rdout", RDOut, 0);
      chk("midrst flags", {28'h0, LdDone, AdEL, BusErr, Stall}, 0);
      reset = 1'b0;
      tick();
      MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      #1 chk("idle ack ignored", {30'h0, LdDone, MemRd}, 0);

      // Request during DONE is held off until the following IDLE cycle
      LdType = 3'b001; Addr = 32'h0000_5000; LdReq = 1'b1;
      tick();
      LdReq = 1'b0;
      MemRData = 32'h1111_2222; MemAck = 1'b1;
      tick();
      MemAck = 1'b0; LdReq = 1'b1; Addr = 32'h0000_5004;
      #1 chk("done no_stall", Stall, 0);
      tick();
      #1 chk("done not_accepted", MemRd, 0);
      chk("idle accept stall", Stall, 1);
      tick();
      LdReq = 1'b0;
      #1 chk("late accept memaddr", MemAddr, 32'h0000_5004);
      MemRData = 32'hCAFE_F00D; MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      #1 chk("late accept rdout", RDOut, 32'hCAFE_F00D);
      tick();

      // Back-to-back loads
      do_load(3'b001, 32'h0000_6000, 32'h7654_3210, 0, 32'h7654_3210, "b2b_lw");
      do_load(3'b100, 32'h0000_6002, 32'h7654_3210, 0, 32'h0000_0054, "b2b_lb");

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
